denorm_prenorm: RTL and testbench
=================================

# denorm_prenorm

Operand-side pre-normalizer for the single-precision vector FPU lanes. It accepts a packed IEEE-754 binary32 operand and unpacks it into sign, a 10-bit two's-complement unbiased exponent and a 24-bit mantissa with explicit leading one. Denormal inputs are left-shifted until bit 23 is set, and their exponent is reduced accordingly. This makes it the inverse of the result-side denormalization step: that step right-shifts out to the denormal range, this block shifts back in. It sits between the operand registers and the multiplier/adder datapaths as a 2-stage valid/ready pipeline.

## Interface
Parameters: none; widths are fixed by binary32.
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operand this cycle
- in_data  in  32  packed binary32 operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result this cycle
- out_sign  out  1  operand sign
- out_exp  out  10  unbiased exponent, two's complement
- out_frac  out  24  mantissa, bit 23 = leading one (except zero)
- out_denorm  out  1  input was denormal (exp field 0, fraction ≠ 0)
- out_zero  out  1  input was ±0
- out_inf  out  1  input was ±inf
- out_nan  out  1  input was NaN (quiet or signaling)

## Operation
- Fields: e = in_data[30:23], f = in_data[22:0].
- Stage 1 (S1) registers the sign, e, f, and the class flags. It also registers lzc, the count of leading zeros of f (0..22; don't-care when f = 0).
- Stage 2 (S2) registers the final outputs:
  - Normal (1 ≤ e ≤ 254): out_frac = {1,f}, out_exp = e − 127 (range −126..127).
  - Denormal: out_frac = {0,f} << (lzc+1), out_exp = −127 − lzc (range −127..−149), out_denorm = 1.
  - Zero: out_frac = 0, out_exp = 0, out_zero = 1.
  - Inf (e = 255, f = 0): out_frac = 24'h800000, out_exp = 10'h080, out_inf = 1.
  - NaN (e = 255, f ≠ 0): out_frac = {1,f}, out_exp = 10'h080, out_nan = 1.
- At most one class flag is high per result.
- Exponent arithmetic is 10-bit modulo. No result overflows 10 bits.

## Timing
- Latency: 2 cycles from the in_valid & in_ready edge to out_valid, when there is no backpressure. Throughput is 1 operand per cycle.
- Handshake: a transfer occurs on a clock edge where valid & ready are both high. out_valid and the out_* data stay stable while out_valid & ~out_ready.
- Stage advance:
  - s2_en = ~out_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en. This is combinational from out_ready; there is no skid buffer.
- Full pipeline: with out_ready held low, exactly 2 operands are held and in_ready goes low. Order is preserved and nothing is dropped or duplicated.
- Simultaneous events: on the same edge, S2 can drain, S1 can move to S2, and a new input can be captured into S1.
- Reset, asynchronous: s1_valid = out_valid = 0 immediately. All out_* data and flags = 0. in_ready = 1 after reset.
- Reset mid-stream: all in-flight operands are discarded and no partial result appears.
- Data registers without valid may hold stale values. Only out_valid qualifies the outputs.

## Structure
- Shared package vfpu_pkg holds:
  - EXP_W = 10, FRAC_W = 24, BIAS = 127
  - EXP_SPECIAL = 10'h080
  - the class-flag encoding, shared with the result-side packer
- Sub-module lzc23: combinational leading-zero counter, 23-bit input, 5-bit count output, plus all-zero flag. It is instantiated in front of the S1 register.
- The S2 shifter is a plain 24-bit barrel left shift (5-bit amount, 0..23).

## Test plan
- 0x3F800000 → sign 0, exp 10'h000, frac 24'h800000, all flags 0; out_valid exactly 2 cycles after acceptance.
- 0x00400000 → exp 10'h381 (−127), frac 24'h800000, out_denorm = 1. Also 0x80000001 → sign 1, exp 10'h36B (−149), frac 24'h800000, out_denorm = 1.
- 0x00000000 → out_zero = 1, exp 0, frac 0. 0x7F800000 → out_inf = 1, exp 10'h080. 0x7FC00001 → out_nan = 1, frac 24'hC00001.
- Backpressure: stream 6 operands back-to-back with out_ready = 0 for cycles 3..8. Required: in_ready low once 2 are held, all 6 emerge in order, and the outputs are stable while stalled.
- Stall release with simultaneous input: out_ready rises while in_valid is high. Required: one drain, one shift and one capture on the same edge, with no bubble.
- Assert rst while 2 operands are in flight. Required: out_valid drops asynchronously, in_ready = 1 after release, and the next operand 0x40000000 → exp 10'h001, frac 24'h800000.

Source files
------------

// File: rtl/vfpu_pkg.sv
// Shared definitions for the binary32 vector FPU lanes: field widths, exponent
// constants and the operand class encoding used by both the operand and result sides.
package vfpu_pkg;

  localparam int EXP_W  = 10;
  localparam int FRAC_W = 24;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 10'h080;

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_ZERO   = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_e;

  function automatic fp_class_e classify(input logic [7:0] e, input logic f_zero);
    fp_class_e c;
    if (e == 8'h00)      c = f_zero ? CLS_ZERO : CLS_DENORM;
    else if (e == 8'hFF) c = f_zero ? CLS_INF  : CLS_NAN;
    else                 c = CLS_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/lzc23.sv
// Combinational leading-zero counter for a 23-bit fraction field.
module lzc23 (
  input  logic [22:0] din,
  output logic [4:0]  cnt,
  output logic        all_zero
);

  // Scan LSB to MSB so the highest set bit is the last (winning) assignment.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (din[i]) cnt = 5'(22 - i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/denorm_prenorm.sv
// Operand pre-normalizer: unpacks binary32 into sign / unbiased exponent / 24-bit
// mantissa with explicit leading one, shifting denormals back into normal form.
module denorm_prenorm
  import vfpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_denorm,
  output logic              out_zero,
  output logic              out_inf,
  output logic              out_nan
);

  logic s1_en, s2_en;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  logic [7:0]  s1_e_q,     s1_e_d;
  logic [22:0] s1_f_q,     s1_f_d;
  logic [4:0]  s1_lzc_q,   s1_lzc_d;
  fp_class_e   s1_cls_q,   s1_cls_d;

  logic              out_valid_q, out_valid_d;
  logic              out_sign_q,  out_sign_d;
  logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
  logic [FRAC_W-1:0] out_frac_q,  out_frac_d;
  logic [3:0]        out_flags_q, out_flags_d;  // {denorm, zero, inf, nan}

  logic [4:0]        lzc_cnt;
  logic              f_all_zero;
  logic [4:0]        shamt;
  logic [EXP_W-1:0]  exp_calc;
  logic [FRAC_W-1:0] frac_calc;
  logic [3:0]        flags_calc;

  assign s2_en    = ~out_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  lzc23 u_lzc (
    .din      (in_data[22:0]),
    .cnt      (lzc_cnt),
    .all_zero (f_all_zero)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_e_d     = s1_e_q;
    s1_f_d     = s1_f_q;
    s1_lzc_d   = s1_lzc_q;
    s1_cls_d   = s1_cls_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_data[31];
      s1_e_d     = in_data[30:23];
      s1_f_d     = in_data[22:0];
      s1_lzc_d   = lzc_cnt;
      s1_cls_d   = classify(in_data[30:23], f_all_zero);
    end
  end

  // Denormal mantissa needs lzc+1 places to bring the top set bit up to bit 23.
  assign shamt = s1_lzc_q + 5'd1;

  always_comb begin
    exp_calc   = '0;
    frac_calc  = '0;
    flags_calc = 4'b0000;
    case (s1_cls_q)
      CLS_NORMAL: begin
        exp_calc  = EXP_W'(int'(s1_e_q) - BIAS);
        frac_calc = {1'b1, s1_f_q};
      end
      CLS_DENORM: begin
        exp_calc   = EXP_W'(-BIAS - int'(s1_lzc_q));
        frac_calc  = {1'b0, s1_f_q} << shamt;
        flags_calc = 4'b1000;
      end
      CLS_ZERO: begin
        flags_calc = 4'b0100;
      end
      CLS_INF: begin
        exp_calc   = EXP_SPECIAL;
        frac_calc  = 24'h800000;
        flags_calc = 4'b0010;
      end
      CLS_NAN: begin
        exp_calc   = EXP_SPECIAL;
        frac_calc  = {1'b1, s1_f_q};
        flags_calc = 4'b0001;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    out_flags_d = out_flags_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      out_sign_d  = s1_sign_q;
      out_exp_d   = exp_calc;
      out_frac_d  = frac_calc;
      out_flags_d = flags_calc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_e_q      <= '0;
      s1_f_q      <= '0;
      s1_lzc_q    <= '0;
      s1_cls_q    <= CLS_ZERO;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_e_q      <= s1_e_d;
      s1_f_q      <= s1_f_d;
      s1_lzc_q    <= s1_lzc_d;
      s1_cls_q    <= s1_cls_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sign   = out_sign_q;
  assign out_exp    = out_exp_q;
  assign out_frac   = out_frac_q;
  assign out_denorm = out_flags_q[3];
  assign out_zero   = out_flags_q[2];
  assign out_inf    = out_flags_q[1];
  assign out_nan    = out_flags_q[0];

endmodule

// File: tb/tb_denorm_prenorm.sv
// Directed bench for denorm_prenorm: class vectors, latency, backpressure and
// mid-stream reset, all against hand-computed expectations.
module tb_denorm_prenorm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_frac;
  logic        out_denorm, out_zero, out_inf, out_nan;

  int assertions = 0;
  int failures   = 0;

  denorm_prenorm dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_frac   (out_frac),
    .out_denorm (out_denorm),
    .out_zero   (out_zero),
    .out_inf    (out_inf),
    .out_nan    (out_nan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    assertions++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] flags();
    return {out_denorm, out_zero, out_inf, out_nan};
  endfunction

  // One operand through an idle pipeline; checks 2-cycle latency and all fields.
  task automatic run_single(input string name, input logic [31:0] d, input logic s,
                            input logic [9:0] e, input logic [23:0] f, input logic [3:0] fl);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check({name, ".in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ".valid_c1"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, ".valid_c2"}, out_valid, 1'b1);
    check({name, ".sign"}, out_sign, s);
    check({name, ".exp"},  out_exp,  e);
    check({name, ".frac"}, out_frac, f);
    check({name, ".flags"}, flags(), fl);
    $display("op %s: in=%08h sign=%0b exp=%03h frac=%06h flags=%04b",
             name, d, out_sign, out_exp, out_frac, flags());
  endtask

  function automatic logic [31:0] mk(input int k);
    return {1'b0, 8'(127 + k), 23'(k * 3 + 1)};
  endfunction

  initial begin
    int sent, rcvd, cyc;
    logic accept, fire, stall_prev, saw_full;
    logic [9:0]  prev_exp;
    logic [23:0] prev_frac;
    int rcv_cyc[6];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.in_ready",  in_ready,  1'b1);
    check("rst.exp",       out_exp,   10'h000);
    check("rst.frac",      out_frac,  24'h000000);
    check("rst.flags",     flags(),   4'b0000);
    @(negedge clk);
    rst = 1'b0;

    run_single("one",    32'h3F800000, 1'b0, 10'h000, 24'h800000, 4'b0000);
    run_single("dn_top", 32'h00400000, 1'b0, 10'h381, 24'h800000, 4'b1000);
    run_single("dn_min", 32'h80000001, 1'b1, 10'h36B, 24'h800000, 4'b1000);
    run_single("zero",   32'h00000000, 1'b0, 10'h000, 24'h000000, 4'b0100);
    run_single("inf",    32'h7F800000, 1'b0, 10'h080, 24'h800000, 4'b0010);
    run_single("nan",    32'h7FC00001, 1'b0, 10'h080, 24'hC00001, 4'b0001);
    run_single("negmax", 32'hFF7FFFFF, 1'b1, 10'h07F, 24'hFFFFFF, 4'b0000);

    // Backpressure stream: 6 operands, out_ready low for cycles 3..8.
    sent = 0; rcvd = 0; stall_prev = 1'b0; saw_full = 1'b0;
    prev_exp = '0; prev_frac = '0;
    for (cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3 && cyc <= 8) ? 1'b0 : 1'b1;
      in_valid  = (sent < 6);
      in_data   = mk(sent);
      #1;
      check("bp.in_ready", in_ready, !((sent - rcvd) == 2 && !out_ready));
      if ((sent - rcvd) == 2 && !out_ready) saw_full = 1'b1;
      if (stall_prev) begin
        check("bp.hold_valid", out_valid, 1'b1);
        check("bp.hold_exp",   out_exp,   prev_exp);
        check("bp.hold_frac",  out_frac,  prev_frac);
      end
      fire = out_valid && out_ready;
      if (fire) begin
        check("bp.exp",  out_exp,  10'(rcvd));
        check("bp.frac", out_frac, {1'b1, 23'(rcvd * 3 + 1)});
        rcv_cyc[rcvd] = cyc;
        $display("bp out #%0d cyc=%0d exp=%03h frac=%06h", rcvd, cyc, out_exp, out_frac);
      end
      accept     = in_valid && in_ready;
      stall_prev = out_valid && !out_ready;
      prev_exp   = out_exp;
      prev_frac  = out_frac;
      @(posedge clk);
      if (accept) sent++;
      if (fire)   rcvd++;
    end
    in_valid = 1'b0;
    check("bp.count", rcvd, 6);
    check("bp.saw_full", saw_full, 1'b1);
    // After release, each output follows the previous one on the next cycle.
    for (int i = 2; i < 6; i++)
      if (i < rcvd) check("bp.no_bubble", rcv_cyc[i], rcv_cyc[i-1] + 1);

    // Mid-stream reset with two operands in flight.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3F800000;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr.full_valid", out_valid, 1'b1);
    check("mr.full_ready", in_ready,  1'b0);
    rst = 1'b1;
    #1;
    check("mr.async_valid", out_valid, 1'b0);
    check("mr.in_ready",    in_ready,  1'b1);
    check("mr.frac",        out_frac,  24'h000000);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr.no_ghost", out_valid, 1'b0);
    end
    run_single("post_rst", 32'h40000000, 1'b0, 10'h001, 24'h800000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
